// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch/M-stage requesters, the port arbiter and
// the single-port memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) ();
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              stall_if;

    logic              m_read;
    logic              m_write;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [REG_W-1:0]  m_dst;
    logic              m_done;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;
    logic [REG_W-1:0]  m_rdst;
    logic              stall_m;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, m_read, m_write, m_addr, m_wdata, m_dst, mem_rdata,
        output if_rdata, if_ready, stall_if, m_done, m_rvalid, m_rdata, m_rdst, stall_m,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, m_read, m_write, m_addr, m_wdata, m_dst, mem_rdata,
        input  if_rdata, if_ready, stall_if, m_done, m_rvalid, m_rdata, m_rdst, stall_m,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-port fixed-latency memory shared by instruction fetch
// and the M stage; M wins ties from idle, a completion hands the port over.
//
// state   | meaning
// IDLE    | port unused, grant on any eligible request
// BUSY_M  | M access in flight, completes when cnt==0 after the strobe cycle
// BUSY_IF | fetch access in flight, completes when cnt==0 after the strobe cycle
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int REG_W   = 3,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY_M, BUSY_IF} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       op_is_write;

    logic m_req, done_m, done_if, free, m_elig, if_elig;

    // The strobe cycle itself is not counted, so completion lands LATENCY
    // cycles after mem_en, exactly when mem_rdata is valid.
    always_comb begin
        m_req   = bus.m_read | bus.m_write;
        done_m  = (state == BUSY_M)  && (cnt == 4'd0) && !bus.mem_en;
        done_if = (state == BUSY_IF) && (cnt == 4'd0) && !bus.mem_en;
        free    = (state == IDLE) || done_m || done_if;
        m_elig  = m_req && !done_m;
        if_elig = bus.if_req && !done_if;
    end

    always_comb begin
        bus.if_ready = done_if;
        bus.if_rdata = done_if ? bus.mem_rdata : {DATA_W{1'b0}};
        bus.m_done   = done_m;
        bus.m_rvalid = done_m & ~op_is_write;
        bus.m_rdata  = done_m ? bus.mem_rdata : {DATA_W{1'b0}};
        bus.stall_m  = reset_n & m_req & ~done_m;
        bus.stall_if = reset_n & bus.if_req & ~done_if;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            op_is_write   <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= {ADDR_W{1'b0}};
            bus.mem_wdata <= {DATA_W{1'b0}};
            bus.m_rdst    <= {REG_W{1'b0}};
        end else begin
            bus.mem_en <= 1'b0;
            if (free) begin
                if (m_elig) begin
                    // both read and write high is treated as a store
                    bus.mem_en   <= 1'b1;
                    bus.mem_we   <= bus.m_write;
                    bus.mem_addr <= bus.m_addr;
                    if (bus.m_write) bus.mem_wdata <= bus.m_wdata;
                    bus.m_rdst   <= bus.m_dst;
                    op_is_write  <= bus.m_write;
                    cnt          <= CNT_LOAD;
                    state        <= BUSY_M;
                end else if (if_elig) begin
                    bus.mem_en   <= 1'b1;
                    bus.mem_we   <= 1'b0;
                    bus.mem_addr <= bus.if_addr;
                    cnt          <= CNT_LOAD;
                    state        <= BUSY_IF;
                end else begin
                    state <= IDLE;
                end
            end else if (!bus.mem_en) begin
                cnt <= cnt - 4'd1;
            end
        end
    end
endmodule
